// File: rtl/conv1_filter_engine_if.sv
// Bundle of every handshake and memory-port signal between the conv1 filter
// engine (master side) and its surroundings: window source, weight/bias
// memories and the activation writer (slave side).
interface conv1_filter_engine_if #(
    parameter int N_TAPS = 27
);
    logic                    weights_ready;
    logic                    win_valid;
    logic                    win_ready;
    logic [8*N_TAPS-1:0]     win_data;
    logic [9:0]              w_addr;
    logic signed [7:0]       w_data;
    logic [4:0]              b_addr;
    logic signed [7:0]       b_data;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [7:0]       out_data;
    logic [4:0]              out_ch;
    logic                    out_last;

    modport master (
        input  weights_ready, win_valid, win_data, w_data, b_data, out_ready,
        output win_ready, w_addr, b_addr, out_valid, out_data, out_ch, out_last
    );

    modport slave (
        output weights_ready, win_valid, win_data, w_data, b_data, out_ready,
        input  win_ready, w_addr, b_addr, out_valid, out_data, out_ch, out_last
    );
endinterface

// File: rtl/conv1_filter_engine.sv
// First-layer 3x3x3 convolution stage: one latched 27-tap window, all filters
// computed one after another on a single MAC, with bias add, ReLU and int8
// requantisation, results streamed one channel at a time.
module conv1_filter_engine #(
    parameter int N_TAPS    = 27,
    parameter int N_FILT    = 28,
    parameter int FRAC_BITS = 6,
    parameter int ACC_W     = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    conv1_filter_engine_if.master  bus
);
    localparam int A_W = 10;
    localparam int F_W = 5;
    localparam logic [4:0]     T_LAST = 5'(N_TAPS - 1);
    localparam logic [F_W-1:0] F_LAST = F_W'(N_FILT - 1);
    localparam logic [A_W-1:0] A_STEP = A_W'(N_FILT);

    typedef enum logic [1:0] {IDLE, MAC, FINAL, OUT} state_t;

    state_t                   state_q, state_d;
    logic [8*N_TAPS-1:0]      win_q, win_d;
    logic [4:0]               t_q, t_d;
    logic [F_W-1:0]           f_q, f_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [A_W-1:0]           w_addr_q, w_addr_d;
    logic [F_W-1:0]           b_addr_q, b_addr_d;
    logic                     out_valid_q, out_valid_d;
    logic [7:0]               out_data_q, out_data_d;
    logic [F_W-1:0]           out_ch_q, out_ch_d;
    logic                     out_last_q, out_last_d;

    logic                     win_ready;
    logic                     win_fire;
    logic [4:0]               act_idx;
    logic signed [7:0]        act;
    logic signed [15:0]       prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  bias_ext;
    logic signed [ACC_W-1:0]  sum;
    logic signed [ACC_W-1:0]  shifted;
    logic [7:0]               relu_sat;

    assign win_ready = (state_q == IDLE) && bus.weights_ready;
    assign win_fire  = bus.win_valid && win_ready;

    // w_data lags w_addr by one cycle, so the MAC consumes the previous tap;
    // in FINAL the counter already sits on the last tap.
    assign act_idx  = (state_q == FINAL) ? t_q : ((t_q == 5'd0) ? 5'd0 : t_q - 5'd1);
    assign act      = win_q[8*act_idx +: 8];
    assign prod     = act * bus.w_data;
    assign prod_ext = {{(ACC_W-16){prod[15]}}, prod};
    assign bias_ext = {{(ACC_W-8-FRAC_BITS){bus.b_data[7]}}, bus.b_data, {FRAC_BITS{1'b0}}};
    assign sum      = acc_q + prod_ext + bias_ext;
    assign shifted  = sum >>> FRAC_BITS;
    // Negative -> 0; any magnitude bit above bit 6 -> saturate to 127.
    assign relu_sat = shifted[ACC_W-1]       ? 8'd0 :
                      (|shifted[ACC_W-2:7])  ? 8'd127 : {1'b0, shifted[6:0]};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (win_fire) state_d = MAC;
            MAC:     if (t_q == T_LAST) state_d = FINAL;
            FINAL:   state_d = OUT;
            OUT:     if (bus.out_ready) state_d = (f_q == F_LAST) ? IDLE : MAC;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values; OUT holds everything until out_ready.
    always_comb begin
        win_d       = win_q;
        t_d         = t_q;
        f_d         = f_q;
        acc_d       = acc_q;
        w_addr_d    = w_addr_q;
        b_addr_d    = b_addr_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        case (state_q)
            IDLE: begin
                if (win_fire) begin
                    win_d    = bus.win_data;
                    t_d      = '0;
                    f_d      = '0;
                    acc_d    = '0;
                    w_addr_d = '0;
                    b_addr_d = '0;
                end
            end
            MAC: begin
                if (t_q != 5'd0) acc_d = acc_q + prod_ext;
                if (t_q != T_LAST) begin
                    t_d      = t_q + 5'd1;
                    w_addr_d = w_addr_q + A_STEP;
                end
            end
            FINAL: begin
                acc_d       = sum;
                out_data_d  = relu_sat;
                out_ch_d    = f_q;
                out_last_d  = (f_q == F_LAST);
                out_valid_d = 1'b1;
            end
            OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (f_q != F_LAST) begin
                        f_d      = f_q + 5'd1;
                        t_d      = '0;
                        acc_d    = '0;
                        w_addr_d = {5'd0, 5'(f_q + 5'd1)};
                        b_addr_d = f_q + 5'd1;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; reset abandons any window in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q       <= '0;
            t_q         <= '0;
            f_q         <= '0;
            acc_q       <= '0;
            w_addr_q    <= '0;
            b_addr_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
        end else begin
            win_q       <= win_d;
            t_q         <= t_d;
            f_q         <= f_d;
            acc_q       <= acc_d;
            w_addr_q    <= w_addr_d;
            b_addr_q    <= b_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_last_q  <= out_last_d;
        end
    end

    assign bus.win_ready = win_ready;
    assign bus.w_addr    = w_addr_q;
    assign bus.b_addr    = b_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ch    = out_ch_q;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_conv1_filter_engine.sv
// Bench for conv1_filter_engine: table of window patterns with a scoreboard of
// expected per-channel results, plus weights_ready gating and mid-window reset.
module tb_conv1_filter_engine;
    localparam int NT = 27;
    localparam int NF = 28;

    typedef struct {
        logic [7:0] data;
        logic [4:0] ch;
        logic       last;
    } exp_t;

    // wmode: 0 all 0x40, 1 only tap 0 = 0x20, 2 all zero, 3 random small
    // rmode: 0 ready always, 1 ready 1-of-3, 2 random ready
    typedef struct {
        byte tap;
        int  wmode;
        byte bias;
        int  rmode;
        int  exp_data;   // -1: use reference model
        bit  hold_wr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    conv1_filter_engine_if #(.N_TAPS(NT)) bus ();

    conv1_filter_engine #(.N_TAPS(NT), .N_FILT(NF), .FRAC_BITS(6), .ACC_W(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    byte  wmem [NF*NT];
    byte  bmem [NF];
    byte  taps [NT];
    exp_t sbq  [$];
    vec_t vecs [6];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int rmode = 0;
    int hs_cyc = 0;
    int last_hs_cyc = 0;
    int pop_cnt = 0;
    bit seen_first = 1'b1;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic [4:0] prev_ch;
    logic       prev_last;
    logic [9:0] prev_waddr;

    // Synchronous-read weight/bias memories.
    always @(posedge clk) begin
        bus.w_data <= wmem[bus.w_addr];
        bus.b_data <= bmem[bus.b_addr];
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] model(input int f);
        int s = 0;
        for (int t = 0; t < NT; t++) s += int'(taps[t]) * int'(wmem[t*NF+f]);
        s += int'(bmem[f]) * 64;
        s = s >>> 6;
        if (s < 0) s = 0;
        if (s > 127) s = 127;
        return 8'(s);
    endfunction

    // Output side: drives out_ready, pops the scoreboard on each handshake and
    // checks that a stalled result holds still with no memory address motion.
    always @(negedge clk) begin
        case (rmode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = (cyc % 3 == 0);
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
        if (rst_n) begin
            if (prev_stall) begin
                chk("stall_valid", int'(bus.out_valid), 1);
                chk("stall_data", int'(bus.out_data), int'(prev_data));
                chk("stall_ch", int'(bus.out_ch), int'(prev_ch));
                chk("stall_last", int'(bus.out_last), int'(prev_last));
                chk("stall_waddr", int'(bus.w_addr), int'(prev_waddr));
            end
            if (bus.out_valid && !seen_first) begin
                chk("first_valid_latency", cyc - hs_cyc, 28);
                seen_first = 1'b1;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    chk("out_data", int'(bus.out_data), int'(e.data));
                    chk("out_ch", int'(bus.out_ch), int'(e.ch));
                    chk("out_last", int'(bus.out_last), int'(e.last));
                    pop_cnt++;
                    last_hs_cyc = cyc + 1;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
            prev_ch    = bus.out_ch;
            prev_last  = bus.out_last;
            prev_waddr = bus.w_addr;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic setup_window(input vec_t v);
        exp_t e;
        for (int t = 0; t < NT; t++) begin
            taps[t] = (v.wmode == 3) ? byte'($urandom_range(0, 255)) : v.tap;
            bus.win_data[8*t +: 8] = taps[t];
            for (int f = 0; f < NF; f++) begin
                case (v.wmode)
                    0:       wmem[t*NF+f] = 8'h40;
                    1:       wmem[t*NF+f] = (t == 0) ? 8'h20 : 8'h00;
                    2:       wmem[t*NF+f] = 8'h00;
                    default: wmem[t*NF+f] = byte'(int'($urandom_range(0, 31)) - 16);
                endcase
            end
        end
        for (int f = 0; f < NF; f++)
            bmem[f] = (v.wmode == 3) ? byte'($urandom_range(0, 255)) : v.bias;
        for (int f = 0; f < NF; f++) begin
            e.data = (v.exp_data >= 0) ? 8'(v.exp_data) : model(f);
            e.ch   = 5'(f);
            e.last = (f == NF - 1);
            sbq.push_back(e);
        end
        pop_cnt = 0;
        rmode   = v.rmode;
    endtask

    task automatic send_window(input bit hold_wr);
        int n = 0;
        @(negedge clk);
        bus.win_valid = 1'b1;
        if (hold_wr) begin
            bus.weights_ready = 1'b0;
            repeat (20) begin
                @(negedge clk); #1;
                chk("wr_low_win_ready", int'(bus.win_ready), 0);
                chk("wr_low_no_output", int'(bus.out_valid), 0);
            end
            bus.weights_ready = 1'b1;
            #1;
            chk("wr_high_win_ready", int'(bus.win_ready), 1);
        end else begin
            #1;
        end
        while (!bus.win_ready && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        if (!bus.win_ready) begin
            chk("accept_timeout", 0, 1);
            bus.win_valid = 1'b0;
            return;
        end
        hs_cyc = cyc + 1;
        seen_first = 1'b0;
        @(posedge clk); #1;
        bus.win_valid = 1'b0;
    endtask

    task automatic drain(input int rm);
        int n = 0;
        while (sbq.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            chk("drain_timeout", sbq.size(), 0);
            sbq.delete();
        end else if (rm == 0) begin
            chk("window_cycles", last_hs_cyc - hs_cyc, NF * (NT + 2));
        end
        repeat (3) @(negedge clk);
        #1;
        chk("idle_win_ready", int'(bus.win_ready), 1);
        chk("idle_no_valid", int'(bus.out_valid), 0);
    endtask

    initial begin
        int n;
        bus.weights_ready = 1'b0;
        bus.win_valid     = 1'b0;
        bus.win_data      = '0;
        bus.out_ready     = 1'b0;
        for (int i = 0; i < NF*NT; i++) wmem[i] = 0;
        for (int i = 0; i < NF; i++) bmem[i] = 0;

        vecs[0] = '{8'h40, 0, 8'h00, 0, 127, 1'b0};
        vecs[1] = '{8'h40, 1, 8'h10, 0, 48,  1'b0};
        vecs[2] = '{8'h40, 2, 8'h80, 0, 0,   1'b1};
        vecs[3] = '{8'h40, 1, 8'h10, 1, 48,  1'b0};
        vecs[4] = '{8'h00, 3, 8'h00, 1, -1,  1'b0};
        vecs[5] = '{8'h00, 3, 8'h00, 2, -1,  1'b0};

        repeat (3) @(negedge clk);
        #1;
        chk("rst_win_ready", int'(bus.win_ready), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_last", int'(bus.out_last), 0);
        chk("rst_out_data", int'(bus.out_data), 0);
        chk("rst_out_ch", int'(bus.out_ch), 0);
        chk("rst_w_addr", int'(bus.w_addr), 0);
        chk("rst_b_addr", int'(bus.b_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.weights_ready = 1'b1;

        for (int i = 0; i < 6; i++) begin
            setup_window(vecs[i]);
            send_window(vecs[i].hold_wr);
            drain(vecs[i].rmode);
        end

        // Reset during filter 10's MAC phase, then a clean full window.
        setup_window(vecs[0]);
        send_window(1'b0);
        n = 0;
        while (pop_cnt < 10 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("pre_reset_progress", (pop_cnt >= 10) ? 1 : 0, 1);
        repeat (10) @(negedge clk);
        #1;
        chk("pre_reset_b_addr", int'(bus.b_addr), 10);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", int'(bus.out_valid), 0);
        chk("mid_rst_out_last", int'(bus.out_last), 0);
        chk("mid_rst_out_data", int'(bus.out_data), 0);
        chk("mid_rst_w_addr", int'(bus.w_addr), 0);
        chk("mid_rst_b_addr", int'(bus.b_addr), 0);
        sbq.delete();
        seen_first = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        setup_window(vecs[1]);
        send_window(1'b0);
        drain(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/conv1_filter_engine.md
Name: conv1_filter_engine

Overview:
- First-layer 3x3x3 convolution compute stage, directly downstream of the AXI weight/bias loader.
- Accepts one 27-tap int8 activation window and reads kernel and bias values from the loader's on-chip weight/bias memories through synchronous read ports.
- Computes all N_FILT output channels sequentially with a single MAC: bias add, ReLU, requantise to int8.
- Streams channel results to the activation writer.

Parameters:
- N_TAPS, 27, taps per window (3x3 kernel x 3 input channels).
- N_FILT, 28, output filters; weight memory depth is N_TAPS*N_FILT = 756.
- FRAC_BITS, 6, fractional bits of the fixed8 format shared by activations, weights and biases.
- ACC_W, 24, signed accumulator width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- weights_ready  in  1  level; loader done (weight/bias memories valid)
- win_valid  in  1  activation window valid
- win_ready  out  1  engine can accept a window
- win_data  in  8*N_TAPS  signed int8 taps; tap t at bits [8t+7:8t]
- w_addr  out  10  weight memory read address
- w_data  in  8  signed weight; valid 1 cycle after w_addr
- b_addr  out  5  bias memory read address
- b_data  in  8  signed bias; valid 1 cycle after b_addr
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  8  signed int8 result, ReLU-applied
- out_ch  out  5  filter index of out_data
- out_last  out  1  high with the final filter (N_FILT-1) of a window

Behaviour:
- Reset (async, rst_n low): state IDLE; win_ready, out_valid, out_last = 0; out_data, out_ch, w_addr, b_addr = 0; accumulator and counters cleared. Reset mid-window abandons the window; no partial output.
- Weight layout (Keras HWIO flatten): w_addr = t*N_FILT + f, for tap t and filter f. b_addr = f.
- IDLE:
  - win_ready = weights_ready.
  - On win_valid && win_ready, latch win_data, set f = 0, t = 0, go to MAC.
  - weights_ready is sampled only in IDLE.
- MAC (N_TAPS cycles):
  - Drive w_addr for tap t, t = 0..N_TAPS-1, one per cycle.
  - Drive b_addr = f throughout.
  - Each cycle, add the product of the previous tap's activation and w_data (sign-extended to ACC_W) into acc.
  - acc is cleared on entry.
  - After t = N_TAPS-1 issues, go to FINAL.
- FINAL (1 cycle):
  - Add the last product, plus b_data sign-extended and shifted left by FRAC_BITS.
  - Then arithmetic-shift right by FRAC_BITS (floor).
  - Apply ReLU (negative -> 0), then saturate to 127.
  - Register into out_data; out_ch = f; out_last = (f == N_FILT-1); out_valid = 1. Go to OUT.
- OUT:
  - Hold out_data, out_ch, out_last and out_valid stable until out_ready.
  - On handshake, if f < N_FILT-1: f++, return to MAC (acc cleared).
  - Otherwise deassert out_valid, return to IDLE; win_ready may assert the next cycle.
- Timing:
  - Minimum per filter: N_TAPS + 2 cycles (29 at defaults), i.e. 812 cycles per window with out_ready held high.
  - First out_valid rises 28 cycles after the window handshake edge.
- Back-pressure: out_ready low stalls in OUT indefinitely; no memory reads are issued while stalled.
- win_ready is low in every state except IDLE; no window overlap.
- Worst-case |acc| = 27*128*128 + 128*2^FRAC_BITS < 2^23, so ACC_W = 24 cannot overflow.

Test Plan:
- All taps = 0x40 (1.0), all weights = 0x40, all biases = 0 -> each channel: sum = 27.0, saturates -> out_data = 127 for ch 0..27. out_last only on ch 27. 28 outputs total.
- Taps = 0x40, weight[t*28+f] = 0 except weight[f] = 0x20 (0.5), bias[f] = 0x10 -> out_data = 0x20 + 0x10 = 48 per channel.
- Bias = 0x80 (-2.0), all weights 0 -> out_data = 0 (ReLU) on all channels.
- out_ready toggled 1-of-3 cycles -> results and order are identical to the free-running case; out_data/out_ch stay stable while out_valid && !out_ready; w_addr never advances while in OUT.
- weights_ready = 0 with win_valid = 1 -> win_ready stays 0 and no outputs. Raise weights_ready -> window accepted the next edge, first out_valid 28 cycles later.
- rst_n pulsed low at filter 10 mid-MAC -> outputs drop immediately. After release, a new window yields a full, correct 28-channel sequence starting at ch 0.
